pc_sequencer: RTL and testbench

- Multicycle PC controller for the MIPS core: owns the PC register and sequences fetch and execute.
- Drives the instruction-memory fetch handshake and pulses the IR load.
- Forms the word-addressed sequential PC (PC + 1).
- Selects the next PC from sequential, branch or jump sources when the main control signals that the instruction has finished.

---
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch handshake between the PC
// sequencer (master) and the instruction memory (slave).
//   imem_req   - master -> slave, fetch request, held until imem_ready
//   imem_addr  - master -> slave, word address of the fetch (the current PC)
//   imem_ready - slave -> master, instruction valid this cycle
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle PC controller. Owns the PC, runs the
// IDLE -> FETCH -> EXEC loop, pulses the IR load when a fetch completes and
// picks the next PC (jump > branch > sequential) when execution finishes.
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   i_run               permits new fetches
//   bus (master)        imem_req / imem_addr / imem_ready fetch handshake
//   o_ir_load           one-cycle pulse, latch instruction into IR
//   i_exec_done         current instruction finished
//   i_branch_taken      branch resolved taken, destination i_branch_target
//   i_jump              unconditional jump, destination i_jump_target
//   i_halt              stop after the current instruction
//   o_pc, o_pc_plus1    PC and registered PC+1 (captured at fetch completion)
//   o_state             0=IDLE 1=FETCH 2=EXEC 3=HALTED
//   o_halted            high in HALTED
//   o_instr_count       retired-instruction counter
module pc_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  pc_sequencer_if.master    bus,
  output logic              o_ir_load,
  input  logic              i_exec_done,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_halt,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus1,
  output logic [1:0]        o_state,
  output logic              o_halted,
  output logic [31:0]       o_instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_pc_plus1;
  logic [ADDR_W-1:0] w_pc_plus1_nxt;
  logic [31:0]       r_instr_count;
  logic [31:0]       w_instr_count_nxt;
  logic              r_halted;
  logic              w_imem_req;
  logic              w_ir_load;

  // Next-state, next-register values and the decoded handshake outputs.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pc_plus1_nxt    = r_pc_plus1;
    w_instr_count_nxt = r_instr_count;
    w_imem_req        = 1'b0;
    w_ir_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // The request stays up until the memory answers; run only gates
        // the start of a fetch, never an issued one.
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_load      = 1'b1;
          w_pc_plus1_nxt = r_pc + ADDR_ONE;
          w_state_nxt    = ST_EXEC;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_EXEC: begin
        // Redirect inputs and halt only matter in the exec_done cycle.
        if (i_exec_done) begin
          if (i_jump) begin
            w_pc_nxt = i_jump_target;
          end else if (i_branch_taken) begin
            w_pc_nxt = i_branch_target;
          end else begin
            w_pc_nxt = r_pc_plus1;
          end
          w_instr_count_nxt = r_instr_count + 32'd1;
          if (i_halt) begin
            w_state_nxt = ST_HALTED;
          end else if (i_run) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_HALTED: begin
        // Terminal until reset.
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and architectural registers; reset acts immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_pc_plus1    <= RESET_PC + ADDR_ONE;
      r_instr_count <= 32'd0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pc_plus1    <= w_pc_plus1_nxt;
      r_instr_count <= w_instr_count_nxt;
      r_halted      <= (w_state_nxt == ST_HALTED);
    end
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.imem_addr  = r_pc;
  assign o_ir_load      = w_ir_load;
  assign o_pc           = r_pc;
  assign o_pc_plus1     = r_pc_plus1;
  assign o_state        = r_state;
  assign o_halted       = r_halted;
  assign o_instr_count  = r_instr_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer. Two instances share
// all stimulus: u_dut0 (RESET_PC=0) is the main device, u_dut1
// (RESET_PC=all-ones) covers PC+1 wraparound. Every fetch address expected on
// an ir_load pulse of u_dut0 is queued when the fetch is stimulated and
// popped by a monitor when the pulse appears.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_ready;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;

  logic        ir_load0, halted0, ir_load1, halted1;
  logic [31:0] pc0, pc_plus1_0, count0, pc1, pc_plus1_1, count1;
  logic [1:0]  state0, state1;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  pc_sequencer_if #(.ADDR_W(32)) u_if0 ();
  pc_sequencer_if #(.ADDR_W(32)) u_if1 ();
  assign u_if0.imem_ready = imem_ready;
  assign u_if1.imem_ready = imem_ready;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_run(run), .bus(u_if0), .o_ir_load(ir_load0),
    .i_exec_done(exec_done), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .i_jump(jump), .i_jump_target(jump_target), .i_halt(halt),
    .o_pc(pc0), .o_pc_plus1(pc_plus1_0), .o_state(state0), .o_halted(halted0),
    .o_instr_count(count0)
  );

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_run(run), .bus(u_if1), .o_ir_load(ir_load1),
    .i_exec_done(exec_done), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .i_jump(jump), .i_jump_target(jump_target), .i_halt(halt),
    .o_pc(pc1), .o_pc_plus1(pc_plus1_1), .o_state(state1), .o_halted(halted1),
    .o_instr_count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: each ir_load pulse must match the oldest queued address.
  always @(negedge clk) begin
    if (rst_n && ir_load0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_fetch: unexpected ir_load at imem_addr=%h, none queued", u_if0.imem_addr);
      end else begin
        sb_exp = exp_q.pop_front();
        if (u_if0.imem_addr !== sb_exp || u_if0.imem_req !== 1'b1) begin
          n_err++;
          $display("FAIL sb_fetch: got addr=%h req=%b want addr=%h req=1", u_if0.imem_addr, u_if0.imem_req, sb_exp);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_in();
    run = 1'b0; imem_ready = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; halt = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  // One instruction from IDLE (or FETCH): immediate fetch, immediate exec_done.
  task automatic instr(input logic [31:0] addr, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic h, input logic run_after);
    run = 1'b1;
    next_cyc();
    exp_q.push_back(addr);
    imem_ready = 1'b1;
    next_cyc();
    imem_ready = 1'b0; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    halt = h; exec_done = 1'b1; run = run_after;
    next_cyc();
    exec_done = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 1'b0;
    next_cyc();
    next_cyc();
    settle();
    n_vec++; if (pc0 !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc0, 32'h0); end
    n_vec++; if (pc_plus1_0 !== 32'h1) begin n_err++; $display("FAIL rst_pc_plus1: got %h want %h", pc_plus1_0, 32'h1); end
    n_vec++; if (state0 !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state0); end
    n_vec++; if (count0 !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count0); end
    n_vec++; if (u_if0.imem_req !== 1'b0 || ir_load0 !== 1'b0 || halted0 !== 1'b0) begin n_err++; $display("FAIL rst_outs: got req=%b irl=%b halted=%b want 0 0 0", u_if0.imem_req, ir_load0, halted0); end
    n_vec++; if (pc1 !== 32'hFFFF_FFFF || pc_plus1_1 !== 32'h0) begin n_err++; $display("FAIL rst_pc_wrap: got pc=%h pc+1=%h want ffffffff 00000000", pc1, pc_plus1_1); end
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd2};
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    run = 1'b1; imem_ready = 1'b1; exec_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      n_vec++; if (u_if0.imem_addr !== exp_addr[c]) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", c, u_if0.imem_addr, exp_addr[c]); end
      n_vec++; if (ir_load0 !== (c % 2 == 1)) begin n_err++; $display("FAIL seq_irload[%0d]: got %b want %b", c, ir_load0, (c % 2 == 1)); end
      next_cyc();
    end
    run = 1'b0;
    settle();
    n_vec++; if (state0 !== 2'd2) begin n_err++; $display("FAIL seq_exec_state: got %0d want 2", state0); end
    next_cyc();
    settle();
    n_vec++; if (pc0 !== 32'd3 || pc_plus1_0 !== 32'd3) begin n_err++; $display("FAIL seq_pc: got pc=%h pc+1=%h want 3 3", pc0, pc_plus1_0); end
    n_vec++; if (count0 !== 32'd3 || state0 !== 2'd0) begin n_err++; $display("FAIL seq_count: got cnt=%0d st=%0d want 3 0", count0, state0); end
    clear_in();
  endtask

  task automatic test_fetch_wait();
    instr(32'd3, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    run = 1'b1;
    next_cyc();
    exp_q.push_back(32'h10);
    for (int k = 0; k < 4; k++) begin
      run = (k == 0);
      imem_ready = (k == 3);
      settle();
      n_vec++; if (u_if0.imem_req !== 1'b1 || u_if0.imem_addr !== 32'h10) begin n_err++; $display("FAIL fw_req[%0d]: got req=%b addr=%h want 1 10", k, u_if0.imem_req, u_if0.imem_addr); end
      n_vec++; if (ir_load0 !== (k == 3)) begin n_err++; $display("FAIL fw_irload[%0d]: got %b want %b", k, ir_load0, (k == 3)); end
      next_cyc();
    end
    imem_ready = 1'b1;
    settle();
    n_vec++; if (state0 !== 2'd2 || u_if0.imem_req !== 1'b0) begin n_err++; $display("FAIL fw_exec: got st=%0d req=%b want 2 0", state0, u_if0.imem_req); end
    next_cyc();
    settle();
    n_vec++; if (pc_plus1_0 !== 32'h11 || state0 !== 2'd2) begin n_err++; $display("FAIL fw_stray_ready: got pc+1=%h st=%0d want 11 2", pc_plus1_0, state0); end
    imem_ready = 1'b0; exec_done = 1'b1; run = 1'b0;
    next_cyc();
    settle();
    n_vec++; if (pc0 !== 32'h11 || state0 !== 2'd0 || count0 !== 32'd5) begin n_err++; $display("FAIL fw_done: got pc=%h st=%0d cnt=%0d want 11 0 5", pc0, state0, count0); end
    next_cyc();
    settle();
    n_vec++; if (count0 !== 32'd5 || state0 !== 2'd0) begin n_err++; $display("FAIL fw_idle_stray: got cnt=%0d st=%0d want 5 0", count0, state0); end
    exec_done = 1'b0;
  endtask

  task automatic test_branch_jump();
    instr(32'h11, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    instr(32'h20, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1);
    settle();
    n_vec++; if (u_if0.imem_addr !== 32'h40) begin n_err++; $display("FAIL br_addr: got %h want %h", u_if0.imem_addr, 32'h40); end
    instr(32'h40, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 1'b1);
    settle();
    n_vec++; if (u_if0.imem_addr !== 32'h80 || u_if0.imem_req !== 1'b1) begin n_err++; $display("FAIL jmp_addr: got %h req=%b want 80 1", u_if0.imem_addr, u_if0.imem_req); end
    exec_done = 1'b1;
    next_cyc();
    settle();
    n_vec++; if (state0 !== 2'd1 || count0 !== 32'd8 || pc0 !== 32'h80) begin n_err++; $display("FAIL fetch_stray_done: got st=%0d cnt=%0d pc=%h want 1 8 80", state0, count0, pc0); end
    exec_done = 1'b0;
    exp_q.push_back(32'h80);
    imem_ready = 1'b1;
    next_cyc();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h99; jump = 1'b1; jump_target = 32'h77; halt = 1'b1;
    next_cyc();
    settle();
    n_vec++; if (state0 !== 2'd2 || pc0 !== 32'h80) begin n_err++; $display("FAIL exec_ignore: got st=%0d pc=%h want 2 80", state0, pc0); end
    branch_taken = 1'b0; jump = 1'b0; halt = 1'b0; exec_done = 1'b1; run = 1'b0;
    next_cyc();
    settle();
    n_vec++; if (pc0 !== 32'h81 || state0 !== 2'd0 || count0 !== 32'd9 || halted0 !== 1'b0) begin n_err++; $display("FAIL seq_after_ignore: got pc=%h st=%0d cnt=%0d h=%b want 81 0 9 0", pc0, state0, count0, halted0); end
    clear_in();
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1'b1;
    next_cyc();
    exp_q.push_back(32'h0);
    imem_ready = 1'b1;
    next_cyc();
    imem_ready = 1'b0;
    settle();
    n_vec++; if (pc_plus1_1 !== 32'h0 || pc1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_fetch: got pc=%h pc+1=%h want ffffffff 0", pc1, pc_plus1_1); end
    next_cyc();
    exec_done = 1'b1; run = 1'b0;
    next_cyc();
    exec_done = 1'b0;
    settle();
    n_vec++; if (pc1 !== 32'h0 || state1 !== 2'd0 || count1 !== 32'd1) begin n_err++; $display("FAIL wrap_exec: got pc=%h st=%0d cnt=%0d want 0 0 1", pc1, state1, count1); end
    n_vec++; if (pc0 !== 32'h1) begin n_err++; $display("FAIL wrap_dut0_pc: got %h want 1", pc0); end
  endtask

  task automatic test_halt();
    instr(32'h1, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b1);
    instr(32'h5, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    settle();
    n_vec++; if (pc0 !== 32'h6 || halted0 !== 1'b1 || state0 !== 2'd3 || count0 !== 32'd3) begin n_err++; $display("FAIL halt: got pc=%h h=%b st=%0d cnt=%0d want 6 1 3 3", pc0, halted0, state0, count0); end
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      run = 1'b1; imem_ready = k[0]; exec_done = ~k[0]; jump = 1'b1; jump_target = 32'h55;
      settle();
      n_vec++; if (pc0 !== 32'h6 || state0 !== 2'd3 || count0 !== 32'd3 || u_if0.imem_req !== 1'b0 || ir_load0 !== 1'b0) begin n_err++; $display("FAIL halt_frozen[%0d]: got pc=%h st=%0d cnt=%0d req=%b irl=%b want 6 3 3 0 0", k, pc0, state0, count0, u_if0.imem_req, ir_load0); end
    end
    next_cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (pc0 !== 32'h0 || state0 !== 2'd0 || halted0 !== 1'b0 || count0 !== 32'd0) begin n_err++; $display("FAIL halt_reset: got pc=%h st=%0d h=%b cnt=%0d want 0 0 0 0", pc0, state0, halted0, count0); end
    clear_in();
    next_cyc();
    rst_n = 1'b1;
    instr(32'h0, 1'b1, 32'h33, 1'b1, 32'h44, 1'b1, 1'b1);
    settle();
    n_vec++; if (pc0 !== 32'h33 || state0 !== 2'd3 || halted0 !== 1'b1 || count0 !== 32'd1) begin n_err++; $display("FAIL halt_jump: got pc=%h st=%0d h=%b cnt=%0d want 33 3 1 1", pc0, state0, halted0, count0); end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    instr(32'h0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    run = 1'b1;
    next_cyc();
    exp_q.push_back(32'h44);
    imem_ready = 1'b1;
    next_cyc();
    imem_ready = 1'b0; run = 1'b0;
    next_cyc();
    #2;
    n_vec++; if (state0 !== 2'd2 || pc0 !== 32'h44 || count0 !== 32'd1) begin n_err++; $display("FAIL pre_reset_exec: got st=%0d pc=%h cnt=%0d want 2 44 1", state0, pc0, count0); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (pc0 !== 32'h0 || pc_plus1_0 !== 32'h1 || state0 !== 2'd0 || count0 !== 32'd0) begin n_err++; $display("FAIL async_reset: got pc=%h pc+1=%h st=%0d cnt=%0d want 0 1 0 0", pc0, pc_plus1_0, state0, count0); end
    n_vec++; if (u_if0.imem_req !== 1'b0 || ir_load0 !== 1'b0) begin n_err++; $display("FAIL async_reset_outs: got req=%b irl=%b want 0 0", u_if0.imem_req, ir_load0); end
    next_cyc();
    rst_n = 1'b1;
    exec_done = 1'b1;
    next_cyc();
    next_cyc();
    settle();
    n_vec++; if (count0 !== 32'd0 || state0 !== 2'd0) begin n_err++; $display("FAIL idle_stray_done: got cnt=%0d st=%0d want 0 0", count0, state0); end
    exec_done = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_sequential();
    test_fetch_wait();
    test_branch_jump();
    test_wrap();
    test_halt();
    test_reset_mid_exec();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d queued fetches left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
